// File: rtl/c_d_scheduler_pkg.sv
// Shared types for the blockC -> blockD scheduler: state codes, burst counter, payload.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package c_d_scheduler_pkg;

  // Scheduler state encoding; any other code is treated as illegal and recovers to IDLE
  typedef enum logic [3:0] {
    C_ST_IDLE    = 4'h0,
    C_ST_ARB     = 4'h1,
    C_ST_XFER    = 4'h2,
    C_ST_HOLDOFF = 4'h3
  } cStateT;

  // Largest burst a single grant may run before re-arbitration
  localparam int C_ANOTHER_SIZE = 10;

  // Burst beat counter, wide enough for C_ANOTHER_SIZE
  typedef logic [4-1:0] cBurstCntT;

  // blockD payload
  typedef logic [2:0] dT;
  typedef struct packed {
    dT dat;
  } dSt;

  // Map the programmed limit onto the legal range: 0 or oversize means the maximum
  function automatic cBurstCntT c_eff_limit(input logic [3:0] lim);
    cBurstCntT res;
    if (lim == 4'd0 || int'(lim) > C_ANOTHER_SIZE) begin
      res = cBurstCntT'(C_ANOTHER_SIZE);
    end else begin
      res = lim;
    end
    return res;
  endfunction

endpackage

// File: rtl/c_d_scheduler_rr_pick.sv
// Round-robin priority picker: first valid requester after last_grant, wrapping.
// Latency: purely combinational.
// Backpressure: none; found=0 when no requester is valid.
module c_rr_pick
  import c_d_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_vld,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  logic [IDX_W-1:0] pos;

  // Scan last_grant+1 .. last_grant+NUM_REQ (mod NUM_REQ); the first hit wins
  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_vld[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/c_d_scheduler.sv
// Round-robin scheduler sharing the single blockD port among NUM_REQ blockC requesters.
// Latency: req_vld in IDLE -> d_vld two cycles later; data path is a combinational pass-through.
// Backpressure: d_rdy is forwarded to the granted requester only; others see req_rdy=0.
module c_d_scheduler
  import c_d_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [3:0]             burst_limit,
  input  logic [NUM_REQ-1:0]     req_vld,
  input  logic [NUM_REQ*3-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_rdy,
  output logic                   d_vld,
  output logic [2:0]             d_data,
  input  logic                   d_rdy,
  output logic [IDX_W-1:0]       d_src,
  output logic [3:0]             state,
  output logic                   burst_done
);

  cStateT           state_q, state_d;
  logic [IDX_W-1:0] d_src_q, d_src_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  cBurstCntT        cnt_q, cnt_d;
  cBurstCntT        lim_q, lim_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             sel_vld;
  dSt               sel_pay;
  logic             in_xfer;
  logic             beat;
  logic             last_beat;
  logic             xfer_exit;

  c_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_vld    (req_vld),
    .last_grant (last_grant_q),
    .idx        (pick_idx),
    .found      (pick_found)
  );

  // Select the granted requester's valid and payload
  always_comb begin
    sel_vld     = 1'b0;
    sel_pay.dat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (d_src_q == IDX_W'(i)) begin
        sel_vld     = req_vld[i];
        sel_pay.dat = req_data[3*i +: 3];
      end
    end
  end

  assign in_xfer    = (state_q == C_ST_XFER);
  assign d_vld      = in_xfer & sel_vld;
  assign d_data     = sel_pay.dat;
  assign beat       = d_vld & d_rdy;
  assign last_beat  = beat && (cnt_q == cBurstCntT'(lim_q - cBurstCntT'(1)));
  // Leave on the final beat, or when the owner has nothing to offer this cycle
  assign xfer_exit  = in_xfer && (last_beat || !sel_vld);
  assign burst_done = xfer_exit;
  assign d_src      = d_src_q;
  assign state      = state_q;

  // Forward d_rdy to the granted requester only, and only while transferring
  always_comb begin
    req_rdy = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_rdy[i] = in_xfer && (d_src_q == IDX_W'(i)) && d_rdy;
    end
  end

  // Next-state and grant bookkeeping
  always_comb begin
    state_d      = state_q;
    d_src_d      = d_src_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    lim_d        = lim_q;
    case (state_q)
      C_ST_IDLE: begin
        if (enable && |req_vld) state_d = C_ST_ARB;
      end
      C_ST_ARB: begin
        if (pick_found) begin
          state_d = C_ST_XFER;
          d_src_d = pick_idx;
          cnt_d   = '0;
          lim_d   = c_eff_limit(burst_limit);
        end else begin
          // requester withdrew between IDLE and ARB
          state_d = C_ST_IDLE;
        end
      end
      C_ST_XFER: begin
        if (beat)      cnt_d   = cnt_q + cBurstCntT'(1);
        if (xfer_exit) state_d = C_ST_HOLDOFF;
      end
      C_ST_HOLDOFF: begin
        last_grant_d = d_src_q;
        state_d      = (enable && |req_vld) ? C_ST_ARB : C_ST_IDLE;
      end
      default: state_d = C_ST_IDLE;
    endcase
  end

  // State registers; reset points the round-robin pointer so requester 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= C_ST_IDLE;
      d_src_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      cnt_q        <= '0;
      lim_q        <= cBurstCntT'(C_ANOTHER_SIZE);
    end else begin
      state_q      <= state_d;
      d_src_q      <= d_src_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      lim_q        <= lim_d;
    end
  end

endmodule

// File: tb/tb_c_d_scheduler.sv
// Testbench for c_d_scheduler: requester models feed queued payloads, a scoreboard
// checks every accepted beat (source and data) in the expected grant order.
module tb_c_d_scheduler;

  localparam int N = 4;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic [3:0]    burst_limit;
  logic [N-1:0]  req_vld;
  logic [N*3-1:0] req_data;
  logic [N-1:0]  req_rdy;
  logic          d_vld;
  logic [2:0]    d_data;
  logic          d_rdy;
  logic [1:0]    d_src;
  logic [3:0]    state;
  logic          burst_done;

  c_d_scheduler #(.NUM_REQ(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .burst_limit (burst_limit),
    .req_vld     (req_vld),
    .req_data    (req_data),
    .req_rdy     (req_rdy),
    .d_vld       (d_vld),
    .d_data      (d_data),
    .d_rdy       (d_rdy),
    .d_src       (d_src),
    .state       (state),
    .burst_done  (burst_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] src;
    logic [2:0] dat;
  } beat_t;

  typedef struct {
    logic [3:0] lim;
    int         src;
    int         beats;
  } vec_t;

  beat_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // requester model: cnt items queued, ptr items accepted
  int cnt[N];
  int ptr[N];

  // per-step observations
  int         cyc, beat_cnt, bd_cnt, bd_src, bd_cyc, hold_cnt, first_vld;
  logic [3:0] st_now;
  logic [3:0] rdy_now;
  logic [2:0] dat_now;
  logic       vld_now;
  int         src_now;

  function automatic logic [2:0] item(int i, int k);
    return 3'((5*i + k + 1) % 8);
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(int i, int from, int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.src = 2'(i);
      b.dat = item(i, from + k);
      exp_q.push_back(b);
    end
  endtask

  task automatic sb_check();
    beat_t b;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_unexpected: got src %0d data %0d, expected no beat", d_src, d_data);
    end else begin
      b = exp_q.pop_front();
      chk("sb_src", int'(d_src), int'(b.src));
      chk("sb_dat", int'(d_data), int'(b.dat));
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      if (ptr[i] < cnt[i]) begin
        req_vld[i]        = 1'b1;
        req_data[3*i +: 3] = item(i, ptr[i]);
      end else begin
        req_vld[i]        = 1'b0;
        req_data[3*i +: 3] = 3'd0;
      end
    end
  endtask

  task automatic clear_stats();
    cyc = 0; beat_cnt = 0; bd_cnt = 0; bd_src = -1; bd_cyc = -1;
    hold_cnt = 0; first_vld = -1;
  endtask

  // One cycle: drive at negedge, sample 1ns later, advance requester models
  task automatic step();
    drive_reqs();
    #1;
    st_now  = state;
    vld_now = d_vld;
    src_now = int'(d_src);
    rdy_now = req_rdy;
    dat_now = d_data;
    if (burst_done) begin bd_cnt++; bd_src = int'(d_src); bd_cyc = cyc; end
    if (state == 4'h3) hold_cnt++;
    if (d_vld && first_vld < 0) first_vld = cyc;
    if (rst_n && d_vld && d_rdy) begin beat_cnt++; sb_check(); end
    if (rst_n) begin
      for (int i = 0; i < N; i++) if (req_vld[i] && req_rdy[i]) ptr[i]++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_until_bd(int target, int budget);
    for (int n = 0; n < budget && bd_cnt < target; n++) step();
    chk("bd_reached", bd_cnt, target);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_vld = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) begin cnt[i] = 0; ptr[i] = 0; end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_stats();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    int   xfer_cyc;
    logic prev_stall;
    logic [2:0] prev_dat;

    tbl[0] = '{4'd0,  1, 10};
    tbl[1] = '{4'd15, 1, 10};
    tbl[2] = '{4'd1,  3, 1};
    tbl[3] = '{4'd4,  2, 4};
    tbl[4] = '{4'd10, 0, 10};
    tbl[5] = '{4'd11, 1, 10};
    tbl[6] = '{4'd7,  3, 7};

    rst_n = 1'b0; enable = 1'b0; burst_limit = 4'd0; d_rdy = 1'b0;
    req_vld = '0; req_data = '0;
    for (int i = 0; i < N; i++) begin cnt[i] = 0; ptr[i] = 0; end
    clear_stats();

    // reset state
    @(negedge clk); #1;
    chk("rst_state", int'(state), 0);
    chk("rst_d_vld", int'(d_vld), 0);
    chk("rst_req_rdy", int'(req_rdy), 0);
    chk("rst_d_src", int'(d_src), 0);
    chk("rst_burst_done", int'(burst_done), 0);

    // single requester: latency, 3 beats, exit on valid drop, back to IDLE
    do_reset();
    enable = 1'b1; burst_limit = 4'd4; d_rdy = 1'b1;
    cnt[0] = 3; push_exp(0, 0, 3);
    repeat (9) step();
    chk("single_first_vld_cyc", first_vld, 2);
    chk("single_beats", beat_cnt, 3);
    chk("single_bd_cyc", bd_cyc, 5);
    chk("single_bd_count", bd_cnt, 1);
    chk("single_bd_src", bd_src, 0);
    chk("single_holdoff", hold_cnt, 1);
    chk("single_end_state", int'(st_now), 0);
    chk("single_sb_empty", exp_q.size(), 0);

    // table: effective burst limit; a mid-burst limit change must not matter
    for (int t = 0; t < 7; t++) begin
      do_reset();
      enable = 1'b1; d_rdy = 1'b1; burst_limit = tbl[t].lim;
      cnt[tbl[t].src] = 20;
      push_exp(tbl[t].src, 0, tbl[t].beats);
      for (int n = 0; n < 20 && beat_cnt < 1; n++) step();
      burst_limit = 4'd1;
      run_until_bd(1, 40);
      chk("tbl_beats", beat_cnt, tbl[t].beats);
      chk("tbl_src", bd_src, tbl[t].src);
      chk("tbl_sb_empty", exp_q.size(), 0);
    end

    // burst cap then HOLDOFF bubble then re-grant to the same requester
    do_reset();
    enable = 1'b1; d_rdy = 1'b1; burst_limit = 4'd0;
    cnt[1] = 25; push_exp(1, 0, 11);
    run_until_bd(1, 40);
    chk("cap_beats", beat_cnt, 10);
    step();
    chk("cap_holdoff_state", int'(st_now), 3);
    chk("cap_holdoff_vld", int'(vld_now), 0);
    step();
    chk("cap_arb_state", int'(st_now), 1);
    step();
    chk("cap_regrant_state", int'(st_now), 2);
    chk("cap_regrant_src", src_now, 1);
    chk("cap_sb_empty", exp_q.size(), 0);

    // round robin: all continuous, limit 2 -> 0,1,2,3,0
    do_reset();
    enable = 1'b1; d_rdy = 1'b1; burst_limit = 4'd2;
    for (int i = 0; i < N; i++) cnt[i] = 30;
    push_exp(0, 0, 2); push_exp(1, 0, 2); push_exp(2, 0, 2);
    push_exp(3, 0, 2); push_exp(0, 2, 2);
    run_until_bd(5, 100);
    chk("rr_beats", beat_cnt, 10);
    chk("rr_holdoffs", hold_cnt, 4);
    chk("rr_last_src", bd_src, 0);
    chk("rr_sb_empty", exp_q.size(), 0);

    // backpressure: d_rdy toggles, limit 3 on requester 2
    do_reset();
    enable = 1'b1; burst_limit = 4'd3;
    cnt[2] = 3; push_exp(2, 0, 3);
    xfer_cyc = 0; prev_stall = 1'b0; prev_dat = 3'd0;
    for (int n = 0; n < 20 && bd_cnt == 0; n++) begin
      d_rdy = (cyc % 2 == 1);
      step();
      if (st_now == 4'h2) begin
        xfer_cyc++;
        chk("bp_rdy_mirror", int'(rdy_now), int'({1'b0, d_rdy, 2'b00}));
        if (prev_stall) chk("bp_data_stable", int'(dat_now), int'(prev_dat));
        prev_stall = vld_now && !d_rdy;
        prev_dat   = dat_now;
      end
    end
    d_rdy = 1'b1;
    chk("bp_xfer_cycles", xfer_cyc, 6);
    chk("bp_beats", beat_cnt, 3);
    chk("bp_sb_empty", exp_q.size(), 0);

    // enable drop mid-burst: burst completes, no new grant until re-enabled
    do_reset();
    enable = 1'b1; d_rdy = 1'b1; burst_limit = 4'd5;
    cnt[3] = 8; push_exp(3, 0, 8);
    for (int n = 0; n < 20 && beat_cnt < 1; n++) step();
    enable = 1'b0;
    run_until_bd(1, 40);
    chk("en_first_burst", beat_cnt, 5);
    repeat (6) step();
    chk("en_idle_state", int'(st_now), 0);
    chk("en_no_beats", beat_cnt, 5);
    enable = 1'b1;
    run_until_bd(2, 40);
    chk("en_regrant_src", bd_src, 3);
    chk("en_total_beats", beat_cnt, 8);
    chk("en_sb_empty", exp_q.size(), 0);

    // asynchronous reset during the second beat of requester 1's grant
    do_reset();
    enable = 1'b1; d_rdy = 1'b1; burst_limit = 4'd2;
    cnt[0] = 2; cnt[1] = 6;
    push_exp(0, 0, 2); push_exp(1, 0, 1);
    for (int n = 0; n < 30 && beat_cnt < 3; n++) step();
    drive_reqs();
    #1;
    chk("mid_pre_vld", int'(d_vld), 1);
    chk("mid_pre_src", int'(d_src), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", int'(d_vld), 0);
    chk("mid_rst_state", int'(state), 0);
    chk("mid_rst_rdy", int'(req_rdy), 0);
    chk("mid_rst_bd", int'(burst_done), 0);
    @(negedge clk);
    cnt[0] = cnt[0] + 2; push_exp(0, 2, 2);
    rst_n = 1'b1;
    clear_stats();
    run_until_bd(1, 40);
    chk("mid_first_grant_src", bd_src, 0);
    chk("mid_req1_not_consumed", ptr[1], 1);
    chk("mid_sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
